// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-keypad frames and shifts each accepted key's hex code into
// a 16-bit register that feeds the seven-segment driver's four_hex_in.
module keypad_scan #(
  parameter int unsigned SCAN_TICKS      = 3840,
  parameter int unsigned DEBOUNCE_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [15:0] four_hex_out,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned CW = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_TARGET   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  // Row synchronizer
  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;

  // Scan timing and column drive
  logic [TW-1:0] timer_q;
  logic          scan_tick;
  logic [1:0]    col_q;
  logic [1:0]    col_next_c;
  logic [3:0]    col_drv_q;
  logic [3:0]    row_buf_q [4];
  logic          frame_done_q;

  // Frame decode
  logic [15:0]   snapshot_c;
  logic [4:0]    pop_c;
  logic [3:0]    key_idx_c;
  logic          one_key_c;
  logic          no_key_c;
  logic [3:0]    key_code_c;

  // Debounce FSM and outputs
  state_t        state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_c;
  logic          cnt_hit_c;
  logic [15:0]   hex_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;

  // Map a snapshot bit index (row*4 + col) to the key's hex code.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; rows idle high through the external pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= ROW;
      row_sync_q <= row_meta_q;
    end
  end

  // Column dwell timer: reload on zero, which is also the sampling instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= TIMER_RELOAD;
    end else if (timer_q == '0) begin
      timer_q <= TIMER_RELOAD;
    end else begin
      timer_q <= timer_q - TW'(1);
    end
  end

  assign scan_tick  = (timer_q == '0);
  assign col_next_c = col_q + 2'd1;

  // Sample the driven column at the end of its dwell, then move to the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= 2'd0;
      col_drv_q <= 4'b1110;
      for (int i = 0; i < 4; i++) begin
        row_buf_q[i] <= 4'b0000;
      end
    end else if (scan_tick) begin
      row_buf_q[col_q] <= ~row_sync_q;
      col_q            <= col_next_c;
      col_drv_q        <= ~(4'b0001 << col_next_c);
    end
  end

  // A frame is complete one clk after the last column has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= scan_tick && (col_q == 2'd3);
    end
  end

  // Build the row/col snapshot, count pressed keys and locate the (last) one.
  always_comb begin
    snapshot_c = '0;
    pop_c      = '0;
    key_idx_c  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        snapshot_c[r*4 + c] = row_buf_q[c][r];
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (snapshot_c[i]) begin
        pop_c     = pop_c + 5'd1;
        key_idx_c = 4'(i);
      end
    end
  end

  // Multi-key frames fall through as neither "one" nor "none" (ghost rejection).
  assign one_key_c  = (pop_c == 5'd1);
  assign no_key_c   = (pop_c == 5'd0);
  assign key_code_c = key_lut(key_idx_c);

  // Saturating frame counter step and its acceptance/release threshold.
  assign cnt_inc_c = (cnt_q == CNT_TARGET) ? cnt_q : cnt_q + CNT_ONE;
  assign cnt_hit_c = (cnt_inc_c == CNT_TARGET);

  // Debounce FSM: press needs N matching frames, release needs N empty frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      hex_q       <= 16'h0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_done_q) begin
        case (state_q)
          ST_IDLE: begin
            if (one_key_c) begin
              cand_q <= key_code_c;
              if (CNT_TARGET == CNT_ONE) begin
                key_valid_q <= 1'b1;
                key_code_q  <= key_code_c;
                hex_q       <= {hex_q[11:0], key_code_c};
                cnt_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (one_key_c && (key_code_c == cand_q)) begin
              if (cnt_hit_c) begin
                key_valid_q <= 1'b1;
                key_code_q  <= cand_q;
                hex_q       <= {hex_q[11:0], cand_q};
                cnt_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (no_key_c) begin
              if (cnt_hit_c) begin
                cnt_q   <= '0;
                state_q <= ST_IDLE;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign COL          = col_drv_q;
  assign four_hex_out = hex_q;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a matrix keypad model drives ROW from COL, expected
// accepted keys go into a scoreboard queue and are matched against key_valid
// events captured by a negedge monitor.
module tb_keypad_scan;

  localparam int unsigned SCAN_TICKS      = 4;
  localparam int unsigned DEBOUNCE_FRAMES = 3;
  localparam int          FRAME           = 16;
  localparam int          OBS_MAX         = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [15:0] four_hex_out;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys;
  logic [15:0] model_hex;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] hex;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0]  obs_code [OBS_MAX];
  logic [15:0] obs_hex  [OBS_MAX];
  int          obs_cyc  [OBS_MAX];
  int          obs_n = 0;
  int          obs_rd = 0;

  keypad_scan #(
    .SCAN_TICKS      (SCAN_TICKS),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ROW          (ROW),
    .COL          (COL),
    .four_hex_out (four_hex_out),
    .key_code     (key_code),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    ROW = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !COL[c]) ROW[r] = 1'b0;
      end
    end
  end

  // Capture every key_valid cycle as an observed acceptance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_valid !== 1'b0 && obs_n < OBS_MAX) begin
      obs_code[obs_n] <= key_code;
      obs_hex[obs_n]  <= four_hex_out;
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  function automatic logic [15:0] key_at(input int r, input int c);
    return 16'd1 << (r*4 + c);
  endfunction

  function automatic void push_exp(input logic [3:0] code);
    exp_t e;
    model_hex = {model_hex[11:0], code};
    e.code = code;
    e.hex  = model_hex;
    exp_q.push_back(e);
  endfunction

  task automatic hold(input logic [15:0] k, input int frames);
    keys = k;
    repeat (FRAME * frames) @(negedge clk);
  endtask

  // Wait for the negedge right after COL returns to column 0 (start of a frame).
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = COL;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (COL == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = COL;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL frame_align: COL=%b, frame start not seen within 40 clk", COL);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    keys      = '0;
    model_hex = 16'h0000;
    repeat (3) @(negedge clk);
    tests++;
    if (COL !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", COL); end
    tests++;
    if (four_hex_out !== 16'h0000) begin fails++; $display("FAIL reset_hex: got %h want 0000", four_hex_out); end
    tests++;
    if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h want 0", key_code); end
    tests++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", key_valid); end
  endtask

  task automatic test_scan_idle();
    logic [3:0] exp_col;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      tests++;
      if (COL !== exp_col) begin
        fails++;
        $display("FAIL scan_col k=%0d: got %b want %b", k, COL, exp_col);
      end
    end
    hold('0, 2);
    tests++;
    if (obs_n != obs_rd) begin fails++; $display("FAIL idle_no_valid: got %0d key_valid pulses want 0", obs_n - obs_rd); end
    obs_rd = obs_n;
    tests++;
    if (four_hex_out !== 16'h0000) begin fails++; $display("FAIL idle_hex: got %h want 0000", four_hex_out); end
  endtask

  task automatic test_single_key();
    int   c0;
    int   first;
    exp_t e;
    wait_frame_start();
    c0    = cyc;
    first = obs_n;
    push_exp(4'h5);
    hold(key_at(1, 1), 6);
    hold('0, 4);
    tests++;
    if (obs_n <= first || obs_cyc[first] - c0 != 3 * FRAME + 1) begin
      fails++;
      $display("FAIL single_latency: got %0d clk want %0d", (obs_n > first) ? obs_cyc[first] - c0 : -1, 3 * FRAME + 1);
    end
    while (obs_rd < obs_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL single_extra: key_valid code %h hex %h, none required", obs_code[obs_rd], obs_hex[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_code[obs_rd] !== e.code || obs_hex[obs_rd] !== e.hex) begin
          fails++;
          $display("FAIL single_key: got code %h hex %h want code %h hex %h", obs_code[obs_rd], obs_hex[obs_rd], e.code, e.hex);
        end
      end
      obs_rd++;
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL single_missing: %0d accepted keys missing, want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_sequence();
    int         rr [5] = '{0, 0, 0, 0, 3};
    int         cc [5] = '{0, 1, 2, 3, 1};
    logic [3:0] cd [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};
    exp_t       e;
    wait_frame_start();
    for (int i = 0; i < 5; i++) begin
      push_exp(cd[i]);
      hold(key_at(rr[i], cc[i]), 4);
      hold('0, 4);
      if (i == 3) begin
        tests++;
        if (four_hex_out !== 16'h123A) begin fails++; $display("FAIL seq_123A: got %h want 123A", four_hex_out); end
      end
    end
    tests++;
    if (four_hex_out !== 16'h23A0) begin fails++; $display("FAIL seq_23A0: got %h want 23A0", four_hex_out); end
    while (obs_rd < obs_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL seq_extra: key_valid code %h hex %h, none required", obs_code[obs_rd], obs_hex[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_code[obs_rd] !== e.code || obs_hex[obs_rd] !== e.hex) begin
          fails++;
          $display("FAIL seq_key: got code %h hex %h want code %h hex %h", obs_code[obs_rd], obs_hex[obs_rd], e.code, e.hex);
        end
      end
      obs_rd++;
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL seq_missing: %0d accepted keys missing, want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bounce();
    wait_frame_start();
    for (int i = 0; i < 3; i++) begin
      hold(key_at(2, 0), 2);
      hold('0, 1);
    end
    hold('0, 2);
    tests++;
    if (obs_n != obs_rd) begin fails++; $display("FAIL bounce_valid: got %0d key_valid pulses want 0", obs_n - obs_rd); end
    obs_rd = obs_n;
    tests++;
    if (four_hex_out !== model_hex) begin fails++; $display("FAIL bounce_hex: got %h want %h", four_hex_out, model_hex); end
  endtask

  task automatic test_ghost_and_rerelease();
    exp_t e;
    wait_frame_start();
    hold(key_at(0, 0) | key_at(0, 1), 6);
    hold('0, 1);
    tests++;
    if (obs_n != obs_rd) begin fails++; $display("FAIL multi_valid: got %0d key_valid pulses want 0", obs_n - obs_rd); end
    obs_rd = obs_n;
    push_exp(4'h9);
    hold(key_at(2, 2), 4);
    hold('0, 1);
    hold(key_at(2, 2), 4);
    hold('0, 4);
    while (obs_rd < obs_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL repress_extra: key_valid code %h hex %h, none required", obs_code[obs_rd], obs_hex[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_code[obs_rd] !== e.code || obs_hex[obs_rd] !== e.hex) begin
          fails++;
          $display("FAIL repress_key: got code %h hex %h want code %h hex %h", obs_code[obs_rd], obs_hex[obs_rd], e.code, e.hex);
        end
      end
      obs_rd++;
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL repress_missing: %0d accepted keys missing, want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_press();
    exp_t e;
    wait_frame_start();
    hold(key_at(2, 3), 1);
    repeat (8) @(negedge clk);
    rst_n     = 1'b0;
    keys      = '0;
    model_hex = 16'h0000;
    #1;
    tests++;
    if (COL !== 4'b1110) begin fails++; $display("FAIL midrst_col: got %b want 1110", COL); end
    tests++;
    if (four_hex_out !== 16'h0000) begin fails++; $display("FAIL midrst_hex: got %h want 0000", four_hex_out); end
    tests++;
    if (key_code !== 4'h0) begin fails++; $display("FAIL midrst_code: got %h want 0", key_code); end
    tests++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frame_start();
    push_exp(4'hC);
    hold(key_at(2, 3), 3);
    hold('0, 4);
    while (obs_rd < obs_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL midrst_extra: key_valid code %h hex %h, none required", obs_code[obs_rd], obs_hex[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_code[obs_rd] !== e.code || obs_hex[obs_rd] !== e.hex) begin
          fails++;
          $display("FAIL midrst_key: got code %h hex %h want code %h hex %h", obs_code[obs_rd], obs_hex[obs_rd], e.code, e.hex);
        end
      end
      obs_rd++;
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL midrst_missing: %0d accepted keys missing, want 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (four_hex_out !== 16'h000C) begin fails++; $display("FAIL midrst_hex_after: got %h want 000C", four_hex_out); end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost_and_rerelease();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
